tl_source_tracker: RTL and testbench

Bench-side TileLink-UL link checker that sits directly upstream of the TileLink monitor assert wrapper. It taps the same A and D channel signals the monitor consumes. It keeps per-source in-flight state, counts beats, and reports transaction-level violations the monitor's per-beat checks do not cover: orphan responses, source reuse, response mismatch and hangs. It exports an in-flight count and an idle flag so the bench can gate end-of-test.

---
 rtl/tl_source_tracker_pkg.sv | 37 +++
 rtl/tl_source_tracker_if.sv | 28 ++
 rtl/tl_source_tracker_beat_counter.sv | 32 +++
 rtl/tl_source_tracker.sv | 183 ++++++++++++++++++
 tb/tb_tl_source_tracker.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/tl_source_tracker_pkg.sv
// TileLink-UL source tracker: shared types, opcodes and beat math.
// Imported by the interface, the beat counter and the tracker top.
package tl_tracker_pkg;

    localparam logic [2:0] A_PUT_FULL    = 3'd0;
    localparam logic [2:0] A_PUT_PARTIAL = 3'd1;
    localparam logic [2:0] A_GET         = 3'd4;
    localparam logic [2:0] D_ACK         = 3'd0;
    localparam logic [2:0] D_ACK_DATA    = 3'd1;
    localparam logic [2:0] MAX_SIZE      = 3'd6;
    localparam int         BEAT_W        = 9;

    typedef enum logic [2:0] {
        ERR_NONE    = 3'd0,
        ERR_ORPHAN  = 3'd1,
        ERR_REUSE   = 3'd2,
        ERR_OPCODE  = 3'd3,
        ERR_SIZE    = 3'd4,
        ERR_TIMEOUT = 3'd5,
        ERR_BADREQ  = 3'd6
    } err_code_e;

    typedef struct packed {
        logic       valid;
        logic       exp_data;
        logic [2:0] size;
    } entry_t;

    function automatic logic [BEAT_W-1:0] beats(input logic [2:0] size,
                                                input int beat_bytes);
        int lg;
        lg = $clog2(beat_bytes);
        if (int'(size) <= lg) return BEAT_W'(1);
        return BEAT_W'(1 << (int'(size) - lg));
    endfunction

endpackage

// File: rtl/tl_source_tracker_if.sv
// A and D channel tap shared by the bus driver and the tracker.
// The tracker only observes, so every signal is an input on its side.
interface tl_source_tracker_if #(
    parameter int SOURCE_W = 7,
    parameter int ADDR_W   = 31
);
    logic                a_valid;
    logic                a_ready;
    logic [2:0]          a_opcode;
    logic [2:0]          a_size;
    logic [SOURCE_W-1:0] a_source;
    logic [ADDR_W-1:0]   a_address;
    logic                d_valid;
    logic                d_ready;
    logic [2:0]          d_opcode;
    logic [2:0]          d_size;
    logic [SOURCE_W-1:0] d_source;

    modport master (
        output a_valid, a_ready, a_opcode, a_size, a_source, a_address,
        output d_valid, d_ready, d_opcode, d_size, d_source
    );

    modport slave (
        input a_valid, a_ready, a_opcode, a_size, a_source, a_address,
        input d_valid, d_ready, d_opcode, d_size, d_source
    );
endinterface

// File: rtl/tl_source_tracker_beat_counter.sv
// Burst beat counter: flags the first and last beat of a burst.
// busy_next tells the owner whether a burst stays open after this cycle.
module tl_beat_counter
    import tl_tracker_pkg::*;
(
    input  logic              clock,
    input  logic              reset_n,
    input  logic              fire,
    input  logic [BEAT_W-1:0] total,
    output logic              first,
    output logic              last,
    output logic              busy_next
);
    logic [BEAT_W-2:0] cnt;
    logic [BEAT_W-2:0] cnt_next;

    assign first = (cnt == '0);
    assign last  = ((BEAT_W'(cnt) + BEAT_W'(1)) == total);

    // Advance on each fired beat, wrapping to zero after the last one.
    always_comb begin
        cnt_next = cnt;
        if (fire) cnt_next = last ? '0 : cnt + 1'b1;
        busy_next = (cnt_next != '0);
    end

    // Beat position register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) cnt <= '0;
        else          cnt <= cnt_next;
    end
endmodule

// File: rtl/tl_source_tracker.sv
// Per-source in-flight tracker for a TileLink-UL link.
// Flags orphan, reuse, opcode, size, hang and bad-request violations.
module tl_source_tracker
    import tl_tracker_pkg::*;
#(
    parameter int SOURCE_W   = 7,
    parameter int ADDR_W     = 31,
    parameter int BEAT_BYTES = 8,
    parameter int TIMEOUT    = 4096
) (
    input  logic                clock,
    input  logic                reset_n,
    tl_source_tracker_if.slave  link,
    output logic                err_valid,
    output logic [2:0]          err_code,
    output logic [SOURCE_W-1:0] err_source,
    output logic [15:0]         err_count,
    output logic [SOURCE_W:0]   inflight,
    output logic                idle
);
    localparam int          N       = 2 ** SOURCE_W;
    localparam logic [31:0] WD_LAST = 32'(TIMEOUT - 1);

    logic                a_fire, d_fire;
    logic                a_first, a_last, a_busy_n;
    logic                d_first, d_last, d_busy_n;
    logic [BEAT_W-1:0]   a_total, d_total;
    logic                a_put, a_get, a_bad;
    entry_t              tbl [N];
    entry_t              a_ent, d_ent;
    err_code_e           a_code, d_code, e_code;
    logic                a_start, d_start;
    logic                d_bad_q, d_burst_bad, d_free;
    logic                same_free, a_alloc, to_hit;
    logic [31:0]         wd;
    logic [SOURCE_W-1:0] to_src, e_src;
    logic [1:0]          n_err;
    logic [16:0]         cnt_sum;
    logic [SOURCE_W:0]   inflight_n;
    logic [ADDR_W:0]     unused_tap;

    assign unused_tap = {link.a_address, a_last};

    assign a_fire  = link.a_valid & link.a_ready;
    assign d_fire  = link.d_valid & link.d_ready;
    assign a_put   = (link.a_opcode == A_PUT_FULL)
                   | (link.a_opcode == A_PUT_PARTIAL);
    assign a_get   = (link.a_opcode == A_GET);
    assign a_bad   = !(a_put | a_get) | (link.a_size > MAX_SIZE);
    assign a_total = a_put ? beats(link.a_size, BEAT_BYTES) : BEAT_W'(1);
    assign d_total = (link.d_opcode == D_ACK_DATA)
                   ? beats(link.d_size, BEAT_BYTES) : BEAT_W'(1);

    tl_beat_counter u_a_cnt (
        .clock     (clock),
        .reset_n   (reset_n),
        .fire      (a_fire),
        .total     (a_total),
        .first     (a_first),
        .last      (a_last),
        .busy_next (a_busy_n)
    );

    tl_beat_counter u_d_cnt (
        .clock     (clock),
        .reset_n   (reset_n),
        .fire      (d_fire),
        .total     (d_total),
        .first     (d_first),
        .last      (d_last),
        .busy_next (d_busy_n)
    );

    assign a_ent   = tbl[link.a_source];
    assign d_ent   = tbl[link.d_source];
    assign a_start = a_fire & a_first;
    assign d_start = d_fire & d_first;

    // Judge a response on its first beat against the stored entry.
    always_comb begin
        d_code = ERR_NONE;
        if (d_start) begin
            if (!d_ent.valid)
                d_code = ERR_ORPHAN;
            else if (link.d_opcode != (d_ent.exp_data ? D_ACK_DATA : D_ACK))
                d_code = ERR_OPCODE;
            else if (link.d_size != d_ent.size)
                d_code = ERR_SIZE;
        end
    end

    // A bad first beat taints the whole D burst so its last beat frees nothing.
    assign d_burst_bad = d_first ? (d_code != ERR_NONE) : d_bad_q;
    assign d_free      = d_fire & d_last & !d_burst_bad;
    assign same_free   = d_free & (link.d_source == link.a_source);

    // Judge a request on its first beat; a same-cycle free makes reuse legal.
    always_comb begin
        a_code = ERR_NONE;
        if (a_start) begin
            if (a_bad)
                a_code = ERR_BADREQ;
            else if (a_ent.valid && !same_free)
                a_code = ERR_REUSE;
        end
    end

    assign a_alloc    = a_start & (a_code == ERR_NONE);
    assign inflight_n = inflight + (SOURCE_W+1)'(a_alloc)
                      - (SOURCE_W+1)'(d_free);
    assign to_hit     = (inflight != '0) & !d_fire & (wd == WD_LAST);

    // Lowest outstanding source is blamed for a hang.
    always_comb begin
        to_src = '0;
        for (int i = N - 1; i >= 0; i--)
            if (tbl[i].valid) to_src = SOURCE_W'(i);
    end

    // Pick the reported error (D over A over hang) and count all of them.
    always_comb begin
        e_code = ERR_NONE;
        e_src  = '0;
        if (d_code != ERR_NONE) begin
            e_code = d_code;
            e_src  = link.d_source;
        end else if (a_code != ERR_NONE) begin
            e_code = a_code;
            e_src  = link.a_source;
        end else if (to_hit) begin
            e_code = ERR_TIMEOUT;
            e_src  = to_src;
        end
        n_err   = {1'b0, d_code != ERR_NONE} + {1'b0, a_code != ERR_NONE}
                + {1'b0, to_hit};
        cnt_sum = {1'b0, err_count} + 17'(n_err);
    end

    // Source table: free first so a same-source allocate wins.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < N; i++) tbl[i] <= '0;
        end else begin
            if (d_free) tbl[link.d_source].valid <= 1'b0;
            if (a_alloc)
                tbl[link.a_source] <= '{valid: 1'b1, exp_data: a_get,
                                        size: link.a_size};
        end
    end

    // Remember whether the open D burst started with an error.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)     d_bad_q <= 1'b0;
        else if (d_start) d_bad_q <= (d_code != ERR_NONE);
    end

    // Hang watchdog: runs while anything is outstanding, rearms after firing.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)                         wd <= '0;
        else if (inflight == '0 || d_fire)    wd <= '0;
        else if (to_hit)                      wd <= '0;
        else                                  wd <= wd + 32'd1;
    end

    // Registered status and error outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            err_valid  <= 1'b0;
            err_code   <= 3'd0;
            err_source <= '0;
            err_count  <= '0;
            inflight   <= '0;
            idle       <= 1'b1;
        end else begin
            err_valid  <= (e_code != ERR_NONE);
            err_code   <= e_code;
            err_source <= e_src;
            err_count  <= cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
            inflight   <= inflight_n;
            idle       <= (inflight_n == '0) & !a_busy_n & !d_busy_n;
        end
    end
endmodule

// File: tb/tb_tl_source_tracker.sv
// Directed bench for tl_source_tracker with hand-computed expectations.
// Drives the link a few ns after each rising edge and samples there too.
module tb_tl_source_tracker;
    import tl_tracker_pkg::*;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        err_valid;
    logic [2:0]  err_code;
    logic [6:0]  err_source;
    logic [15:0] err_count;
    logic [7:0]  inflight;
    logic        idle;
    int          checks = 0;
    int          errors = 0;
    int          pulses;
    int          first_pulse;

    always #5 clock = ~clock;

    tl_source_tracker_if #(.SOURCE_W(7), .ADDR_W(31)) link ();

    tl_source_tracker #(
        .SOURCE_W   (7),
        .ADDR_W     (31),
        .BEAT_BYTES (8),
        .TIMEOUT    (16)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .link       (link),
        .err_valid  (err_valid),
        .err_code   (err_code),
        .err_source (err_source),
        .err_count  (err_count),
        .inflight   (inflight),
        .idle       (idle)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic a_set(input logic v, input logic [2:0] op,
                         input logic [2:0] sz, input logic [6:0] src);
        link.a_valid   = v;
        link.a_ready   = 1'b1;
        link.a_opcode  = op;
        link.a_size    = sz;
        link.a_source  = src;
        link.a_address = {24'd0, src};
    endtask

    task automatic d_set(input logic v, input logic [2:0] op,
                         input logic [2:0] sz, input logic [6:0] src);
        link.d_valid  = v;
        link.d_ready  = 1'b1;
        link.d_opcode = op;
        link.d_size   = sz;
        link.d_source = src;
    endtask

    task automatic a_beat(input logic [2:0] op, input logic [2:0] sz,
                          input logic [6:0] src);
        a_set(1'b1, op, sz, src);
        tick();
        link.a_valid = 1'b0;
    endtask

    task automatic d_beat(input logic [2:0] op, input logic [2:0] sz,
                          input logic [6:0] src);
        d_set(1'b1, op, sz, src);
        tick();
        link.d_valid = 1'b0;
    endtask

    task automatic chk_err(input string tag, input logic v,
                           input logic [2:0] code, input logic [6:0] src,
                           input logic [15:0] cnt);
        check({tag, "_valid"}, err_valid, v);
        if (v) begin
            check({tag, "_code"}, err_code, code);
            check({tag, "_src"}, err_source, src);
        end
        check({tag, "_count"}, err_count, cnt);
    endtask

    initial begin
        a_set(1'b0, 3'd0, 3'd0, 7'd0);
        d_set(1'b0, 3'd0, 3'd0, 7'd0);
        link.a_ready = 1'b0;
        link.d_ready = 1'b0;
        repeat (3) tick();
        chk_err("reset", 1'b0, 3'd0, 7'd0, 16'd0);
        check("reset_code", err_code, 0);
        check("reset_src", err_source, 0);
        check("reset_inflight", inflight, 0);
        check("reset_idle", idle, 1);
        reset_n = 1'b1;
        tick();

        // Get src 5 size 6, eight AccessAckData beats
        a_beat(A_GET, 3'd6, 7'd5);
        check("get5_inflight", inflight, 1);
        check("get5_idle", idle, 0);
        for (int i = 0; i < 8; i++) begin
            d_beat(D_ACK_DATA, 3'd6, 7'd5);
            check("get5_beat_err", err_valid, 0);
            if (i == 6) begin
                check("get5_mid_inflight", inflight, 1);
                check("get5_mid_idle", idle, 0);
            end
        end
        check("get5_done_inflight", inflight, 0);
        check("get5_done_idle", idle, 1);

        // PutFull src 3 size 5, four A beats with a stalled cycle
        a_beat(A_PUT_FULL, 3'd5, 7'd3);
        check("put3_inflight", inflight, 1);
        a_set(1'b1, A_PUT_FULL, 3'd5, 7'd3);
        link.a_ready = 1'b0;
        tick();
        check("put3_stall_idle", idle, 0);
        for (int i = 0; i < 3; i++) a_beat(A_PUT_FULL, 3'd5, 7'd3);
        chk_err("put3_a", 1'b0, 3'd0, 7'd0, 16'd0);
        check("put3_a_inflight", inflight, 1);
        d_beat(D_ACK, 3'd5, 7'd3);
        chk_err("put3_d", 1'b0, 3'd0, 7'd0, 16'd0);
        check("put3_d_inflight", inflight, 0);
        check("put3_d_idle", idle, 1);

        // Orphan response
        d_beat(D_ACK, 3'd3, 7'd9);
        chk_err("orphan9", 1'b1, 3'd1, 7'd9, 16'd1);
        tick();
        check("orphan9_pulse", err_valid, 0);

        // Reuse, opcode and size mismatches on source 2
        a_beat(A_GET, 3'd3, 7'd2);
        check("get2_inflight", inflight, 1);
        a_beat(A_GET, 3'd3, 7'd2);
        chk_err("reuse2", 1'b1, 3'd2, 7'd2, 16'd2);
        d_beat(D_ACK, 3'd3, 7'd2);
        chk_err("opc2", 1'b1, 3'd3, 7'd2, 16'd3);
        check("opc2_inflight", inflight, 1);
        d_beat(D_ACK_DATA, 3'd2, 7'd2);
        chk_err("size2", 1'b1, 3'd4, 7'd2, 16'd4);
        d_beat(D_ACK_DATA, 3'd3, 7'd2);
        chk_err("get2_ok", 1'b0, 3'd0, 7'd0, 16'd4);
        check("get2_inflight_end", inflight, 0);

        // Unsupported opcode and oversize request
        a_beat(3'd2, 3'd3, 7'd1);
        chk_err("bad_op", 1'b1, 3'd6, 7'd1, 16'd5);
        a_beat(A_GET, 3'd7, 7'd1);
        chk_err("bad_size", 1'b1, 3'd6, 7'd1, 16'd6);
        check("bad_inflight", inflight, 0);

        // A and D errors in one cycle
        a_set(1'b1, 3'd3, 3'd3, 7'd0);
        d_set(1'b1, D_ACK, 3'd3, 7'd11);
        tick();
        link.a_valid = 1'b0;
        link.d_valid = 1'b0;
        chk_err("dual", 1'b1, 3'd1, 7'd11, 16'd8);

        // Same-cycle free and reallocate of source 4
        a_beat(A_GET, 3'd4, 7'd4);
        d_beat(D_ACK_DATA, 3'd4, 7'd4);
        check("swap_mid_inflight", inflight, 1);
        a_set(1'b1, A_GET, 3'd3, 7'd4);
        d_set(1'b1, D_ACK_DATA, 3'd4, 7'd4);
        tick();
        link.a_valid = 1'b0;
        link.d_valid = 1'b0;
        chk_err("swap", 1'b0, 3'd0, 7'd0, 16'd8);
        check("swap_inflight", inflight, 1);
        d_beat(D_ACK_DATA, 3'd3, 7'd4);
        chk_err("swap_done", 1'b0, 3'd0, 7'd0, 16'd8);
        check("swap_done_inflight", inflight, 0);
        check("swap_done_idle", idle, 1);

        // Hang on source 7: one pulse per 16 cycles without D progress
        a_beat(A_GET, 3'd3, 7'd7);
        pulses = 0;
        first_pulse = -1;
        for (int i = 0; i < 32; i++) begin
            tick();
            if (err_valid) begin
                pulses++;
                if (first_pulse < 0) first_pulse = i;
                check("hang_code", err_code, 5);
                check("hang_src", err_source, 7);
            end
        end
        check("hang_pulses", pulses, 2);
        check("hang_first", first_pulse, 15);
        check("hang_count", err_count, 10);

        // Asynchronous reset mid-wait, then a trailing response
        repeat (3) tick();
        #2;
        reset_n = 1'b0;
        #1;
        check("rst_inflight", inflight, 0);
        check("rst_idle", idle, 1);
        check("rst_count", err_count, 0);
        tick();
        reset_n = 1'b1;
        tick();
        d_beat(D_ACK_DATA, 3'd3, 7'd7);
        chk_err("rst_orphan", 1'b1, 3'd1, 7'd7, 16'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
